img_writer: RTL

//  Avalon-MM slave that lets the HPS push RGB pixels into an on-chip FIFO and replays them as a VGA stream.

---
 rtl/img_writer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/img_writer.sv
// img_writer: Avalon-MM slave that buffers HPS-written RGB pixels and replays them as a self-timed VGA stream.
// Defining IMG_WRITER_TEST_PATTERN_EN adds an 8-bar colour generator selected by control bit 2.

module img_writer #(
    parameter int FIFO_DEPTH = 1024,
    parameter int PIX_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [7:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        blank_n
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DW-1:0] DIV_LAST   = DW'(PIX_DIV - 1);
    localparam logic [15:0]   H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0]   V_LAST     = 16'(V_TOTAL - 1);
    localparam logic [15:0]   H_ACT      = 16'(H_ACTIVE);
    localparam logic [15:0]   V_ACT      = 16'(V_ACTIVE);
    localparam logic [15:0]   H_SYNC_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0]   H_SYNC_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0]   V_SYNC_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0]   V_SYNC_END = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        STREAM
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   div_q;
    logic [15:0]     hcnt_q;
    logic [15:0]     vcnt_q;
    logic            hs_q;
    logic            vs_q;
    logic            blank_q;
    logic [23:0]     rgb_q;
    logic [23:0]     rgb_d;

    logic [23:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   count_q;
    logic            underflow_q;
    logic            overflow_q;
    logic            enable_q;

    logic tick, frame_wrap, active, streaming, show;
    logic fifo_empty, fifo_full;
    logic push_req, ctrl_wr, flush, enable_d;
    logic pop, push_ok, underflow_evt, overflow_evt;
    logic pattern_on, pattern_rd;
    logic [23:0] pattern_rgb;
    logic unused_wdata;

    assign unused_wdata = ^writedata[7:2];

    assign tick       = (div_q == DIV_LAST);
    assign frame_wrap = tick && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    assign active     = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign streaming  = (state_q == STREAM);
    assign show       = streaming && active;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LVL_FULL);

    assign push_req = chipselect && write && (address == 8'd0);
    assign ctrl_wr  = chipselect && write && (address == 8'd1);
    assign flush    = ctrl_wr && writedata[1];
    assign enable_d = ctrl_wr ? writedata[0] : enable_q;

`ifdef IMG_WRITER_TEST_PATTERN_EN
    logic       pattern_q;
    logic [2:0] bar_idx;

    assign bar_idx     = 3'(({16'd0, hcnt_q} << 3) / 32'(H_ACTIVE));
    assign pattern_rgb = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
    assign pattern_on  = pattern_q;
    assign pattern_rd  = pattern_q;
`else
    assign pattern_rgb = '0;
    assign pattern_on  = 1'b0;
    assign pattern_rd  = 1'b0;
`endif

    // An empty FIFO on an active tick is an underflow, so a same-cycle push still lands.
    assign pop           = show && tick && !pattern_on && !fifo_empty;
    assign underflow_evt = show && tick && !pattern_on && fifo_empty;
    assign push_ok       = push_req && (!fifo_full || pop);
    assign overflow_evt  = push_req && fifo_full && !pop;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rgb_d = '0;
        if (show) begin
            if (pattern_on) begin
                rgb_d = pattern_rgb;
            end else if (!fifo_empty) begin
                rgb_d = mem_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect && read) begin
            case (address)
                8'd0:    readdata = {11'd0, streaming, overflow_q, underflow_q,
                                     fifo_empty, fifo_full, 16'(count_q)};
                8'd1:    readdata = {29'd0, pattern_rd, 1'b0, enable_q};
                8'd2:    readdata = {vcnt_q, hcnt_q};
                default: readdata = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DW'(1);
            if (tick) begin
                if (hcnt_q == H_LAST) begin
                    hcnt_q <= '0;
                    vcnt_q <= (vcnt_q == V_LAST) ? '0 : vcnt_q + 16'd1;
                end else begin
                    hcnt_q <= hcnt_q + 16'd1;
                end
            end
            hs_q    <= !((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END));
            vs_q    <= !((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END));
            blank_q <= active;
            rgb_q   <= rgb_d;
        end
    end

    // NOTE: the pixel store has no reset; flushing the pointers is enough to empty it.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= writedata[31:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            enable_q    <= 1'b0;
`ifdef IMG_WRITER_TEST_PATTERN_EN
            pattern_q   <= 1'b0;
`endif
        end else begin
            if (ctrl_wr) begin
                enable_q  <= writedata[0];
`ifdef IMG_WRITER_TEST_PATTERN_EN
                pattern_q <= writedata[2];
`endif
            end
            if (flush) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                underflow_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
                case ({push_ok, pop})
                    2'b10:   count_q <= count_q + LW'(1);
                    2'b01:   count_q <= count_q - LW'(1);
                    default: count_q <= count_q;
                endcase
                if (underflow_evt) underflow_q <= 1'b1;
                if (overflow_evt)  overflow_q  <= 1'b1;
            end
        end
    end

    // Leaving STREAM reacts to the bus write itself, so the stream stops on the following clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:       if (enable_q) state_q <= WAIT_FRAME;
                WAIT_FRAME: begin
                    if (!enable_d || flush) state_q <= IDLE;
                    else if (frame_wrap)    state_q <= STREAM;
                end
                STREAM:     if (!enable_d || flush) state_q <= IDLE;
                default:    state_q <= IDLE;
            endcase
        end
    end

    assign VGA_R   = rgb_q[23:16];
    assign VGA_G   = rgb_q[15:8];
    assign VGA_B   = rgb_q[7:0];
    assign HSYNC   = hs_q;
    assign VSYNC   = vs_q;
    assign blank_n = blank_q;

endmodule
